seg7_reader: RTL and testbench
==============================

# seg7_reader

Recovers the 5-bit character code from a sampled 7-segment pattern. It is the inverse of the character-to-segment decoder already in the design. A pattern must be seen on a configurable number of consecutive valid samples before it is looked up. The resulting code is then offered on a valid/ready output. The block sits between a segment-sampling front end (display snooper or test fixture) and any consumer of character codes.

## Interface
- STABLE_CNT, 3: identical valid samples required before a pattern is accepted; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- seg_valid  input  1  seg carries a sample this cycle.
- seg  input  7  pattern {a,b,c,d,e,f,g}; seg[6]=a.
- code_ready  input  1  consumer accepts code this cycle.
- code_valid  output  1  code/code_ambig/code_err hold a result.
- code  output  5  character code; same numbering as the decoder's 5-bit select, code[4] = MSB.
- code_ambig  output  1  pattern maps to two codes; the lower code is reported.
- code_err  output  1  pattern is non-blank and not in the table; code = 0.
- drop_cnt  output  8  saturating count of results lost to backpressure (see Configuration).

## Operation
- Lookup:
  - 0001110→0, 1011111→1, 0011100→2, 1100111→3, 0111100→4, 0000101→5, 1110000→6.
  - 1101101→7 (ambig, also 10), 0111110→8, 0011111→9, 0110011→11, 1111111→12, 0101010→13, 1001111→14.
  - 1111110→15 (ambig, also 18), 1111001→16, 1110111→17, 1100000→19.
  - 0000000 is blank. Any other pattern → err.
- FSM states:
  - IDLE: no candidate.
  - COUNT: candidate held, counting matches.
  - HOLD: candidate accepted; waits for a change.
- Only cycles with seg_valid=1 advance the FSM. seg_valid=0 cycles change nothing.
- Any state, sample ≠ candidate (or state IDLE): candidate←seg, cnt←1, go to COUNT. If STABLE_CNT=1, accept immediately.
- COUNT, sample = candidate: cnt←cnt+1. When cnt reaches STABLE_CNT, accept and go to HOLD.
- HOLD, sample = candidate: no action. A held pattern is never re-emitted.
- Accepting a non-blank pattern produces a result (code, ambig, err). Accepting blank produces no result but still enters HOLD. Repeated characters must therefore be separated by a stable blank or another pattern.
- Output register, one entry:
  - Loads a result when code_valid=0, or when code_valid=1 and code_ready=1 in the same cycle (accept-and-replace).
  - If code_valid=1 and code_ready=0 at result time, the new result is dropped, the old one is kept, and drop_cnt increments (saturating at 255).
- code_valid deasserts after a cycle with code_ready=1 and no new result.
- Reset values:
  - Outputs: code_valid=0, code=0, code_ambig=0, code_err=0, drop_cnt=0.
  - Internal: state=IDLE, candidate=0, cnt=0.
  - Reset mid-count or mid-hold discards everything.

## Timing
- Latency: code_valid rises the cycle after the clock edge sampling the accepting seg_valid sample.
- Minimum acceptance: STABLE_CNT valid cycles; gaps in seg_valid extend it without breaking the match.
- code/code_ambig/code_err stay stable while code_valid=1 and code_ready=0.
- Throughput: at most one result per STABLE_CNT valid samples.

## Configuration
- SEG7_READER_DROP_CNT_EN:
  - Defined: drop_cnt is implemented as specified.
  - Undefined: no counter logic; drop_cnt ties to 0. Drop behaviour is unchanged.

## Structure
- Package seg7_pkg:
  - Pattern constants for all 20 characters plus blank.
  - Code width (5) and segment width (7) localparams.
  - FSM state enum {IDLE, COUNT, HOLD}.
- Sub-module seg7_pat2code: purely combinational pattern → {code, ambig, err, blank}. It is instanced once, fed by the candidate register.

## Test plan
- STABLE_CNT=3; seg=0001110 valid for 3 cycles, code_ready=1 → code_valid for 1 cycle one cycle after 3rd sample, code=0, ambig=0, err=0. Holding the pattern 10 more cycles → no further results.
- seg=1101101 ×3 → code=7, ambig=1. seg=1111110 ×3 → code=15, ambig=1.
- seg=1010101 ×3 → code_valid=1, code=0, err=1. seg=0000000 ×3 → no result.
- 1100000 ×2, 1111111 ×1, 1100000 ×3 → a single result, code=19, after the last sample. seg_valid gaps inserted between samples → same result.
- code_ready=0, then 1100111 ×3, then 0000000 ×3, then 1110111 ×3:
  - code=3 is held.
  - drop_cnt=1 with SEG7_READER_DROP_CNT_EN defined, 0 without.
  - Raising code_ready → one transfer, then code_valid=0.
- Assert rst mid-COUNT (after 2 of 3 samples), then 1 more sample → no result. Reset values on all outputs checked the cycle after rst.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_reader shared types: segment/code widths, pattern table, FSM states.
// Patterns are {a,b,c,d,e,f,g} with segment a in bit 6.
package seg7_pkg;

    localparam int CODE_W = 5;
    localparam int SEG_W  = 7;

    typedef logic [SEG_W-1:0]  seg_t;
    typedef logic [CODE_W-1:0] code_t;

    localparam seg_t PAT_BLANK = 7'b0000000;
    localparam seg_t PAT_0     = 7'b0001110;
    localparam seg_t PAT_1     = 7'b1011111;
    localparam seg_t PAT_2     = 7'b0011100;
    localparam seg_t PAT_3     = 7'b1100111;
    localparam seg_t PAT_4     = 7'b0111100;
    localparam seg_t PAT_5     = 7'b0000101;
    localparam seg_t PAT_6     = 7'b1110000;
    localparam seg_t PAT_7     = 7'b1101101;
    localparam seg_t PAT_8     = 7'b0111110;
    localparam seg_t PAT_9     = 7'b0011111;
    localparam seg_t PAT_10    = 7'b1101101;
    localparam seg_t PAT_11    = 7'b0110011;
    localparam seg_t PAT_12    = 7'b1111111;
    localparam seg_t PAT_13    = 7'b0101010;
    localparam seg_t PAT_14    = 7'b1001111;
    localparam seg_t PAT_15    = 7'b1111110;
    localparam seg_t PAT_16    = 7'b1111001;
    localparam seg_t PAT_17    = 7'b1110111;
    localparam seg_t PAT_18    = 7'b1111110;
    localparam seg_t PAT_19    = 7'b1100000;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_e;

    typedef struct packed {
        code_t code;
        logic  ambig;
        logic  err;
        logic  blank;
    } lookup_t;

endpackage

// File: rtl/seg7_pat2code.sv
// Combinational 7-segment pattern to character code lookup.
// Shared patterns (7/10, 15/18) report the lower code with ambig set.
module seg7_pat2code
    import seg7_pkg::*;
(
    input  seg_t    pat_i,
    output lookup_t res_o
);

    always_comb begin
        res_o = '{code: '0, ambig: 1'b0, err: 1'b0, blank: 1'b0};
        case (pat_i)
            PAT_0:  res_o.code = code_t'(0);
            PAT_1:  res_o.code = code_t'(1);
            PAT_2:  res_o.code = code_t'(2);
            PAT_3:  res_o.code = code_t'(3);
            PAT_4:  res_o.code = code_t'(4);
            PAT_5:  res_o.code = code_t'(5);
            PAT_6:  res_o.code = code_t'(6);
            PAT_7: begin
                res_o.code  = code_t'(7);
                res_o.ambig = 1'b1;
            end
            PAT_8:  res_o.code = code_t'(8);
            PAT_9:  res_o.code = code_t'(9);
            PAT_11: res_o.code = code_t'(11);
            PAT_12: res_o.code = code_t'(12);
            PAT_13: res_o.code = code_t'(13);
            PAT_14: res_o.code = code_t'(14);
            PAT_15: begin
                res_o.code  = code_t'(15);
                res_o.ambig = 1'b1;
            end
            PAT_16: res_o.code = code_t'(16);
            PAT_17: res_o.code = code_t'(17);
            PAT_19: res_o.code = code_t'(19);
            PAT_BLANK: res_o.blank = 1'b1;
            default: res_o.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Debounced 7-segment pattern reader with a one-entry valid/ready output.
// Define SEG7_READER_DROP_CNT_EN to implement the drop_cnt counter.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seg_valid,
    input  logic [6:0]   seg,
    input  logic         code_ready,
    output logic         code_valid,
    output logic [4:0]   code,
    output logic         code_ambig,
    output logic         code_err,
    output logic [7:0]   drop_cnt
);

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    state_e     state_q;
    seg_t       cand_q;
    seg_t       cand_d;
    logic [3:0] cnt_q;

    logic       valid_q;
    code_t      code_q;
    logic       ambig_q;
    logic       err_q;

    logic       new_cand;
    logic       accept;
    logic       result;
    logic       load;
    lookup_t    lk;

    always_comb begin
        new_cand = seg_valid && (state_q == IDLE || seg != cand_q);
        cand_d   = new_cand ? seg : cand_q;
        if (new_cand) begin
            accept = (STABLE == 4'd1);
        end else begin
            accept = seg_valid && state_q == COUNT
                  && (cnt_q + 4'd1 == STABLE);
        end
        result = accept && !lk.blank;
        load   = result && (!valid_q || code_ready);
    end

    // Looks up the next candidate so an accept can load on the same edge.
    seg7_pat2code u_pat2code (
        .pat_i (cand_d),
        .res_o (lk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else if (new_cand) begin
            cand_q  <= cand_d;
            cnt_q   <= 4'd1;
            state_q <= accept ? HOLD : COUNT;
        end else if (seg_valid && state_q == COUNT) begin
            cnt_q <= cnt_q + 4'd1;
            if (accept) begin
                state_q <= HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            code_q  <= '0;
            ambig_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            code_q  <= lk.code;
            ambig_q <= lk.ambig;
            err_q   <= lk.err;
        end else if (code_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef SEG7_READER_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_q;

    assign drop = result && valid_q && !code_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

    assign code_valid = valid_q;
    assign code       = code_q;
    assign code_ambig = ambig_q;
    assign code_err   = err_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with STABLE_CNT = 3.
// Inputs change and outputs are sampled on the falling edge.
module tb_seg7_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       seg_valid;
    logic [6:0] seg;
    logic       code_ready;
    logic       code_valid;
    logic [4:0] code;
    logic       code_ambig;
    logic       code_err;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int xfers    = 0;
    int vcnt     = 0;
    int x0;

`ifdef SEG7_READER_DROP_CNT_EN
    localparam logic [7:0] EXP_DROP = 8'd1;
`else
    localparam logic [7:0] EXP_DROP = 8'd0;
`endif

    always #5 clk = ~clk;

    seg7_reader #(.STABLE_CNT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_valid  (seg_valid),
        .seg        (seg),
        .code_ready (code_ready),
        .code_valid (code_valid),
        .code       (code),
        .code_ambig (code_ambig),
        .code_err   (code_err),
        .drop_cnt   (drop_cnt)
    );

    always @(posedge clk) begin
        if (!rst && code_valid && code_ready) xfers++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic steps(input logic [6:0] p, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            seg       = p;
            seg_valid = v;
            @(negedge clk);
            if (code_valid) vcnt++;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, 32'(code_valid), 0);
        check({tag, "_code"},  32'(code), 0);
        check({tag, "_ambig"}, 32'(code_ambig), 0);
        check({tag, "_err"},   32'(code_err), 0);
        check({tag, "_drop"},  32'(drop_cnt), 0);
    endtask

    initial begin
        rst        = 1'b1;
        seg        = '0;
        seg_valid  = 1'b0;
        code_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;

        steps(7'b0001110, 1'b1, 2);
        check("c0_early", 32'(code_valid), 0);
        steps(7'b0001110, 1'b1, 1);
        check("c0_valid", 32'(code_valid), 1);
        check("c0_code",  32'(code), 0);
        check("c0_ambig", 32'(code_ambig), 0);
        check("c0_err",   32'(code_err), 0);
        vcnt = 0;
        steps(7'b0001110, 1'b1, 10);
        check("c0_norepeat", 32'(vcnt), 0);

        steps(7'b1101101, 1'b1, 3);
        check("c7_valid", 32'(code_valid), 1);
        check("c7_code",  32'(code), 7);
        check("c7_ambig", 32'(code_ambig), 1);
        steps(7'b1111110, 1'b1, 3);
        check("c15_code",  32'(code), 15);
        check("c15_ambig", 32'(code_ambig), 1);
        steps(7'b1010101, 1'b1, 3);
        check("err_valid", 32'(code_valid), 1);
        check("err_code",  32'(code), 0);
        check("err_err",   32'(code_err), 1);
        check("err_ambig", 32'(code_ambig), 0);
        vcnt = 0;
        steps(7'b0000000, 1'b1, 6);
        check("blank_none", 32'(vcnt), 0);

        vcnt = 0;
        steps(7'b1100000, 1'b1, 2);
        steps(7'b1111111, 1'b1, 1);
        steps(7'b1100000, 1'b1, 2);
        check("c19_early", 32'(vcnt), 0);
        steps(7'b1100000, 1'b1, 1);
        check("c19_valid", 32'(code_valid), 1);
        check("c19_code",  32'(code), 19);

        steps(7'b0000000, 1'b1, 3);
        vcnt = 0;
        steps(7'b1100000, 1'b1, 1);
        steps(7'b1010101, 1'b0, 1);
        steps(7'b1100000, 1'b1, 1);
        steps(7'b1111111, 1'b1, 1);
        steps(7'b0000000, 1'b0, 1);
        steps(7'b1100000, 1'b1, 1);
        steps(7'b1010101, 1'b0, 2);
        steps(7'b1100000, 1'b1, 1);
        check("gap_early", 32'(vcnt), 0);
        steps(7'b1100000, 1'b1, 1);
        check("gap_valid", 32'(code_valid), 1);
        check("gap_code",  32'(code), 19);

        steps(7'b0000000, 1'b0, 1);
        check("drain", 32'(code_valid), 0);
        code_ready = 1'b0;
        steps(7'b1100111, 1'b1, 3);
        check("bp_valid", 32'(code_valid), 1);
        check("bp_code",  32'(code), 3);
        steps(7'b0000000, 1'b1, 3);
        steps(7'b1110111, 1'b1, 3);
        check("bp_hold_valid", 32'(code_valid), 1);
        check("bp_hold_code",  32'(code), 3);
        check("bp_hold_err",   32'(code_err), 0);
        check("bp_drop",       32'(drop_cnt), 32'(EXP_DROP));
        x0 = xfers;
        code_ready = 1'b1;
        steps(7'b0000000, 1'b0, 1);
        check("bp_clear", 32'(code_valid), 0);
        steps(7'b0000000, 1'b0, 3);
        check("bp_xfers", 32'(xfers - x0), 1);

        steps(7'b0001110, 1'b1, 2);
        rst = 1'b1;
        steps(7'b0000000, 1'b0, 1);
        check_reset("rst1");
        rst  = 1'b0;
        vcnt = 0;
        steps(7'b0001110, 1'b1, 1);
        steps(7'b0001110, 1'b0, 4);
        check("rst_nores", 32'(vcnt), 0);
        steps(7'b0001110, 1'b1, 1);
        check("rst_recnt", 32'(code_valid), 0);
        steps(7'b0001110, 1'b1, 1);
        check("rst_valid", 32'(code_valid), 1);
        check("rst_code",  32'(code), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
